fifo_stream_reader: RTL and testbench

Read-side controller for the synchronous FIFO: drains the FIFO read port and presents words on a valid/ready stream toward downstream logic. It issues `rd_en` only when a word is available and buffer space is guaranteed, so it never causes a FIFO underflow. It absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, sustains one word per cycle when downstream is always ready, and keeps a read counter plus a sticky underflow error flag for monitoring.

---
 rtl/fifo_stream_reader_if.sv | 25 ++
 rtl/fifo_stream_reader.sv | 92 +++++++++
 tb/tb_fifo_stream_reader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Stream-reader bus: the FIFO read port on one side and the valid/ready
// output stream on the other.
//   master : the reader controller (drives fifo_rd_en, m_data, m_valid)
//   slave  : the environment (the FIFO read port plus the downstream sink)
interface fifo_stream_reader_if #(
  parameter int FIFO_WIDTH = 16
);
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_underflow;
  logic                  fifo_rd_en;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  fifo_empty, fifo_data_out, fifo_underflow, m_ready,
    output fifo_rd_en, m_data, m_valid
  );

  modport slave (
    output fifo_empty, fifo_data_out, fifo_underflow, m_ready,
    input  fifo_rd_en, m_data, m_valid
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO read port (one-cycle read
// latency) into a 2-entry skid buffer and presents the words on a
// valid/ready stream. A read is only requested when a free slot is
// guaranteed for the returning word, so the FIFO is never underflowed by
// this block and one word per cycle is sustained with m_ready held high.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus            fifo_stream_reader_if.master
//                    fifo_empty / fifo_data_out / fifo_underflow (in)
//                    fifo_rd_en (out, combinational)
//                    m_data / m_valid (out, registered), m_ready (in)
//   rd_count       words handed downstream, wraps modulo 2^CNT_WIDTH
//   err_underflow  sticky, set when fifo_underflow is observed high
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_reader_if.master bus,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 err_underflow
);

  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
  logic                  err_q, err_d;

  logic                  pop;
  logic                  rd_en;
  logic [1:0]            occ_after_pop;
  logic [2:0]            credit;

  always_comb begin
    pop           = (occ_q != 2'd0) && bus.m_ready;
    occ_after_pop = occ_q - {1'b0, pop};
    // Slots committed once this cycle settles: words held after the pop
    // plus the word already on its way back from the FIFO.
    credit        = {1'b0, occ_after_pop} + {2'b00, inflight_q};
    rd_en         = rst_n && !bus.fifo_empty && (credit < 3'd2);

    inflight_d    = rd_en;
    occ_d         = credit[1:0];

    head_d        = head_q;
    tail_d        = tail_q;
    if (pop) begin
      head_d = tail_q;
    end
    // The returning word lands in the first slot left free after the pop;
    // with occ=1 and a pop it goes straight to the head.
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        head_d = bus.fifo_data_out;
      end else begin
        tail_d = bus.fifo_data_out;
      end
    end

    rd_count_d = rd_count_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    err_d      = err_q | bus.fifo_underflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      rd_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      rd_count_q <= rd_count_d;
      err_q      <= err_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ_q != 2'd0);
  assign bus.m_data     = head_q;
  assign rd_count       = rd_count_q;
  assign err_underflow  = err_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  logic clk;
  logic rst_n;

  fifo_stream_reader_if #(.FIFO_WIDTH(16)) ifc  ();
  fifo_stream_reader_if #(.FIFO_WIDTH(16)) ifc4 ();

  logic [15:0] rd_count;
  logic        err_underflow;
  logic [3:0]  rd_count4;
  logic        err_underflow4;

  fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.master),
    .rd_count(rd_count), .err_underflow(err_underflow)
  );

  // Narrow-counter copy fed with identical inputs, used for wrap checks.
  fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(ifc4.master),
    .rd_count(rd_count4), .err_underflow(err_underflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench FIFO (read side behaviour) ----------------
  logic [15:0] fq[$];
  logic        fifo_empty_q;
  logic [15:0] fdout;
  logic        uf_q;
  logic        force_uf;
  logic        m_ready_r;
  logic [15:0] exp_q[$];   // words read out of the FIFO, oldest first
  logic [15:0] got_q[$];   // words delivered downstream in this phase

  initial begin
    fifo_empty_q = 1'b1;
    fdout        = 16'h0;
    uf_q         = 1'b0;
    force_uf     = 1'b0;
    m_ready_r    = 1'b0;
  end

  always @(posedge clk) begin
    uf_q <= 1'b0;
    if (ifc.fifo_rd_en) begin
      if (fq.size() == 0) begin
        uf_q <= 1'b1;
      end else begin
        fdout <= fq[0];
        exp_q.push_back(fq[0]);
        void'(fq.pop_front());
      end
    end
    fifo_empty_q <= (fq.size() == 0);
  end

  assign ifc.fifo_empty      = fifo_empty_q;
  assign ifc.fifo_data_out   = fdout;
  assign ifc.fifo_underflow  = uf_q | force_uf;
  assign ifc.m_ready         = m_ready_r;
  assign ifc4.fifo_empty     = fifo_empty_q;
  assign ifc4.fifo_data_out  = fdout;
  assign ifc4.fifo_underflow = uf_q | force_uf;
  assign ifc4.m_ready        = m_ready_r;

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: words issued / landed / delivered, counted as plain integers.
  int   n_land = 0;
  int   n_pop  = 0;
  int   n_infl = 0;
  logic err_m  = 1'b0;
  int   cyc = 0;
  int   rd_cycles = 0, vld_cycles = 0, first_rd = -1, last_rd = -1, first_vld = -1;

  always @(negedge clk) begin
    int   occ_m;
    logic vld_m, pop_m, rd_m;
    if (!rst_n) begin
      chk("reset_outputs",
          {ifc.fifo_rd_en, ifc.m_valid, ifc.m_data, rd_count, err_underflow}, 64'h0);
      n_land = 0; n_pop = 0; n_infl = 0; err_m = 1'b0;
      exp_q.delete();
    end else begin
      occ_m = n_land - n_pop;
      vld_m = (occ_m > 0);
      pop_m = vld_m && m_ready_r;
      rd_m  = !fifo_empty_q && ((occ_m + n_infl - int'(pop_m)) < 2);
      chk("m_valid", ifc.m_valid, vld_m);
      chk("fifo_rd_en", ifc.fifo_rd_en, rd_m);
      chk("rd_count", rd_count, n_pop[15:0]);
      chk("err_underflow", err_underflow, err_m);
      chk("dut4_state", {rd_count4, err_underflow4, ifc4.m_valid, ifc4.fifo_rd_en},
          {n_pop[3:0], err_m, vld_m, rd_m});
      if (vld_m) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 1'b0, 1'b1);
        end else begin
          chk("m_data", ifc.m_data, exp_q[0]);
        end
      end
      if (ifc.fifo_rd_en) begin
        rd_cycles++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (ifc.m_valid) begin
        vld_cycles++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (pop_m && exp_q.size() > 0) begin
        got_q.push_back(exp_q.pop_front());
        n_pop++;
      end
      n_land += n_infl;
      n_infl  = int'(rd_m);
      err_m   = err_m | ifc.fifo_underflow;
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    fifo_empty_q = 1'b0;
  endtask

  task automatic clr_phase();
    got_q.delete();
    rd_cycles = 0; vld_cycles = 0; first_rd = -1; last_rd = -1; first_vld = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("async_reset_now",
        {ifc.fifo_rd_en, ifc.m_valid, ifc.m_data, rd_count, err_underflow, rd_count4}, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    clr_phase();
  endtask

  task automatic wait_delivered(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (got_q.size() < n) chk("delivery_timeout", got_q.size(), n);
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clr_phase();

    // Idle after reset with an empty FIFO
    repeat (4) tick();
    chk("idle_rd_en", ifc.fifo_rd_en, 1'b0);
    chk("idle_valid", ifc.m_valid, 1'b0);
    chk("idle_rd_cycles", rd_cycles, 0);

    // Streaming, m_ready held high
    m_ready_r = 1'b1;
    for (int i = 1; i <= 8; i++) push(16'(i));
    wait_delivered(8, 40);
    repeat (3) tick();
    chk("stream_rd_cycles", rd_cycles, 8);
    chk("stream_rd_consecutive", last_rd - first_rd, 7);
    chk("stream_vld_cycles", vld_cycles, 8);
    chk("stream_latency", first_vld - first_rd, 2);
    chk("stream_count", rd_count, 16'd8);
    for (int i = 0; i < 8; i++) chk("stream_word", got_q[i], 16'(i + 1));

    // Backpressure
    do_reset();
    m_ready_r = 1'b0;
    for (int i = 1; i <= 8; i++) push(16'(i));
    repeat (6) tick();
    chk("bp_rd_pulses", rd_cycles, 2);
    chk("bp_rd_en_low", ifc.fifo_rd_en, 1'b0);
    chk("bp_valid", ifc.m_valid, 1'b1);
    chk("bp_head", ifc.m_data, 16'h0001);
    repeat (3) tick();
    chk("bp_head_stable", ifc.m_data, 16'h0001);
    m_ready_r = 1'b1;
    wait_delivered(8, 40);
    tick();
    chk("bp_count", rd_count, 16'd8);
    for (int i = 0; i < 8; i++) chk("bp_word", got_q[i], 16'(i + 1));

    // Random backpressure with a concurrent writer
    do_reset();
    begin
      int written = 0;
      int k = 0;
      while (got_q.size() < 1000 && k < 20000) begin
        if (written < 1000 && ($urandom % 4) != 0) begin
          push(16'($urandom_range(0, 65535)));
          written++;
        end
        m_ready_r = 1'($urandom % 2);
        tick();
        k++;
      end
      if (got_q.size() < 1000) chk("random_timeout", got_q.size(), 1000);
    end
    m_ready_r = 1'b1;
    tick();
    chk("random_count", rd_count, 16'd1000);
    chk("random_count4", rd_count4, 4'd8);
    chk("random_no_err", err_underflow, 1'b0);

    // Counter wrap on the 4-bit copy, then sticky error flag
    do_reset();
    for (int i = 0; i < 17; i++) push(16'(16'h0100 + i));
    wait_delivered(17, 60);
    tick();
    chk("wrap_count4", rd_count4, 4'd1);
    chk("wrap_count16", rd_count, 16'd17);
    force_uf = 1'b1;
    tick();
    force_uf = 1'b0;
    tick();
    chk("err_set", {err_underflow, err_underflow4}, 2'b11);
    repeat (4) tick();
    chk("err_sticky", err_underflow, 1'b1);

    // Reset with one word buffered and one in flight
    do_reset();
    chk("err_cleared", err_underflow, 1'b0);
    m_ready_r = 1'b0;
    for (int i = 1; i <= 8; i++) push(16'(i));
    tick();
    tick();
    chk("pre_reset_valid", ifc.m_valid, 1'b1);
    chk("pre_reset_head", ifc.m_data, 16'h0001);
    do_reset();
    m_ready_r = 1'b1;
    wait_delivered(6, 40);
    tick();
    chk("midrst_first_word", got_q[0], 16'h0003);
    chk("midrst_last_word", got_q[5], 16'h0008);
    chk("midrst_count", rd_count, 16'd6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
